als_filter: RTL and testbench

Downstream consumer of the PmodALS SPI reader. Takes the reader's 8-bit `data` and its `read_flag`, captures one sample per frame, and keeps a moving average over the last 2^LOG2_DEPTH samples in a circular buffer. Publishes the average with a one-cycle valid strobe and derives a hysteretic `dark` indication for the rest of the lab design.

---
 rtl/als_filter.sv | 127 ++++++++++++
 tb/tb_als_filter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/als_filter.sv
// Moving-average filter for PmodALS light samples: one sample per reader frame,
// windowed average over 2^LOG2_DEPTH samples, plus a hysteretic dark flag.
module als_filter #(
  parameter int          LOG2_DEPTH = 3,
  parameter logic [7:0]  TH_LOW     = 8'd40,
  parameter logic [7:0]  TH_HIGH    = 8'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       read_flag,
  output logic [7:0] avg,
  output logic       avg_valid,
  output logic       dark,
  output logic       filled,
  output logic [1:0] state_dbg
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 8 + LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, UPDATE = 2'd2} state_t;

  state_t                state, next_state;
  logic                  s1, s2, s3;
  logic                  frame_edge;
  logic                  pending;
  logic [7:0]            sample;
  logic [7:0]            old_val;
  logic [7:0]            buf_mem [DEPTH];
  logic [SW-1:0]         sum;
  logic [SW-1:0]         new_sum;
  logic [7:0]            new_avg;
  logic [LOG2_DEPTH-1:0] wp;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  clr_pending, do_load, do_update;

  // read_flag is asynchronous: two flops to resynchronise, a third to find the rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= read_flag;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign frame_edge = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A frame edge seen directly in IDLE starts the update without going through pending
  always_comb begin
    next_state  = state;
    clr_pending = 1'b0;
    do_load     = 1'b0;
    do_update   = 1'b0;
    case (state)
      IDLE: begin
        if (pending || frame_edge) begin
          next_state  = LOAD;
          clr_pending = 1'b1;
        end
      end
      LOAD: begin
        do_load    = 1'b1;
        next_state = UPDATE;
      end
      UPDATE: begin
        do_update  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Sum stays exact: it always equals the sum of the buffer, which starts all-zero
  assign new_sum  = sum - SW'(old_val) + SW'(sample);
  assign new_avg  = new_sum[SW-1:LOG2_DEPTH];
  assign cnt_next = (cnt == DEPTH_C) ? cnt : cnt + 1'b1;
  assign filled   = (cnt == DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      sample    <= '0;
      old_val   <= '0;
      sum       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      dark      <= 1'b0;
      wp        <= '0;
      cnt       <= '0;
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      avg_valid <= 1'b0;
      if (clr_pending)     pending <= 1'b0;
      else if (frame_edge) pending <= 1'b1;
      if (frame_edge) sample <= data;
      if (do_load) old_val <= buf_mem[wp];
      if (do_update) begin
        buf_mem[wp] <= sample;
        sum         <= new_sum;
        avg         <= new_avg;
        wp          <= wp + 1'b1;
        cnt         <= cnt_next;
        if (cnt_next == DEPTH_C) begin
          avg_valid <= 1'b1;
          if (new_avg < TH_LOW)       dark <= 1'b1;
          else if (new_avg > TH_HIGH) dark <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_als_filter.sv
// Bench for als_filter: directed and random frames, a window-average model
// compared every cycle, plus hand-computed checkpoints.
module tb_als_filter;

  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 1 << LOG2_DEPTH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       read_flag = 1'b0;
  logic [7:0] avg;
  logic       avg_valid;
  logic       dark;
  logic       filled;
  logic [1:0] state_dbg;

  als_filter #(.LOG2_DEPTH(LOG2_DEPTH), .TH_LOW(8'd40), .TH_HIGH(8'd60)) dut (
    .clk(clk), .rst(rst), .data(data), .read_flag(read_flag),
    .avg(avg), .avg_valid(avg_valid), .dark(dark), .filled(filled),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int strobe_cnt = 0;

  // Pending frame handed from driver to model: update due at posedge number upd_at
  logic       pend_v = 1'b0;
  logic [7:0] pend_d = '0;
  int         upd_at = 0;

  // Model state
  logic [7:0] win_q[$];
  int         m_cnt;
  logic [7:0] m_avg;
  logic       m_dark;
  logic       exp_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    win_q = {};
    for (int i = 0; i < DEPTH; i++) win_q.push_back(8'd0);
    m_cnt  = 0;
    m_avg  = '0;
    m_dark = 1'b0;
    pend_v = 1'b0;
  endtask

  task automatic model_apply(input logic [7:0] d);
    int total;
    win_q.push_back(d);
    void'(win_q.pop_front());
    total = 0;
    foreach (win_q[i]) total += int'(win_q[i]);
    m_avg = 8'(total / DEPTH);
    if (m_cnt < DEPTH) m_cnt++;
    if (m_cnt == DEPTH) begin
      exp_valid = 1'b1;
      if (m_avg < 8'd40)      m_dark = 1'b1;
      else if (m_avg > 8'd60) m_dark = 1'b0;
    end
  endtask

  // Compare process: 1 time unit after every rising edge
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp_valid = 1'b0;
      if (rst) begin
        model_reset();
      end else if (pend_v && cyc == upd_at) begin
        pend_v = 1'b0;
        model_apply(pend_d);
      end
      if (avg_valid === 1'b1) strobe_cnt++;
      chk("avg", 32'(avg), 32'(m_avg));
      chk("dark", 32'(dark), 32'(m_dark));
      chk("filled", 32'(filled), 32'(m_cnt == DEPTH));
      chk("avg_valid", 32'(avg_valid), 32'(exp_valid));
    end
  end

  // Raise read_flag for 'hold' cycles, then leave it low for 'gap' cycles
  task automatic send_frame(input logic [7:0] d, input int hold, input int gap);
    @(negedge clk);
    data      = d;
    read_flag = 1'b1;
    pend_d    = d;
    upd_at    = cyc + 5;
    pend_v    = 1'b1;
    repeat (hold) @(negedge clk);
    read_flag = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_n(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send_frame(d, 6, 14);
  endtask

  // Frame whose UPDATE edge coincides with a reset
  task automatic send_frame_reset(input logic [7:0] d);
    @(negedge clk);
    data      = d;
    read_flag = 1'b1;
    pend_d    = d;
    upd_at    = cyc + 5;
    pend_v    = 1'b1;
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    read_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  int s0;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_avg", 32'(avg), 32'd0);
    chk("reset_valid", 32'(avg_valid), 32'd0);
    chk("reset_dark", 32'(dark), 32'd0);
    chk("reset_filled", 32'(filled), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Fill with 100
    send_n(8'd100, 7);
    chk("fill7_filled", 32'(filled), 32'd0);
    chk("fill7_strobes", 32'(strobe_cnt), 32'd0);
    send_n(8'd100, 1);
    chk("fill8_filled", 32'(filled), 32'd1);
    chk("fill8_avg", 32'(avg), 32'd100);
    chk("fill8_strobes", 32'(strobe_cnt), 32'd1);

    // Wrap and truncation
    send_n(8'd200, 1);
    chk("trunc_avg", 32'(avg), 32'd112);
    chk("trunc_strobes", 32'(strobe_cnt), 32'd2);
    send_n(8'd200, 7);
    chk("wrap_avg", 32'(avg), 32'd200);
    chk("wrap_wp", 32'(dut.wp), 32'd0);

    // Full-scale samples
    send_n(8'd255, 8);
    chk("sat_avg", 32'(avg), 32'd255);
    chk("sat_sum", 32'(dut.sum), 32'd2040);

    // Hysteresis
    send_n(8'd30, 8);
    chk("hyst_dark_set", 32'(dark), 32'd1);
    chk("hyst_avg30", 32'(avg), 32'd30);
    send_n(8'd50, 8);
    chk("hyst_avg50", 32'(avg), 32'd50);
    chk("hyst_dark_hold1", 32'(dark), 32'd1);
    send_n(8'd70, 5);
    chk("hyst_avg62", 32'(avg), 32'd62);
    chk("hyst_dark_clr", 32'(dark), 32'd0);
    send_n(8'd50, 8);
    chk("hyst_dark_hold0", 32'(dark), 32'd0);

    // Random frames with random flag widths and spacing
    for (int i = 0; i < 24; i++) begin
      int hold;
      hold = $urandom_range(3, 10);
      send_frame(8'($urandom_range(0, 255)), hold, 16 - hold + $urandom_range(0, 4));
    end

    // Mid-operation reset on the UPDATE edge of the 5th frame
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_n(8'd77, 4);
    s0 = strobe_cnt;
    send_frame_reset(8'd77);
    chk("midrst_avg", 32'(avg), 32'd0);
    chk("midrst_filled", 32'(filled), 32'd0);
    chk("midrst_sum", 32'(dut.sum), 32'd0);
    send_n(8'd10, 7);
    chk("refill_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("refill7_filled", 32'(filled), 32'd0);
    send_n(8'd10, 1);
    chk("refill_avg", 32'(avg), 32'd10);
    chk("refill_filled", 32'(filled), 32'd1);
    chk("refill_strobe1", 32'(strobe_cnt - s0), 32'd1);

    // Long flag: exactly one update
    s0 = strobe_cnt;
    send_frame(8'd90, 40, 14);
    chk("long_flag_strobes", 32'(strobe_cnt - s0), 32'd1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
